// File: rtl/read_counter.sv
// Read-path sequencing counter: walks PREAMBLE/DATA/POSTAMBLE/GAP/INTERAMBLE for each
// read command and flags the receive windows for the capture datapath.
module read_counter #(
  parameter int unsigned MAX_PRE = 4,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rd_en_i,
  input  logic [2:0] precycle_i,
  input  logic [1:0] postcycle_i,
  input  logic [3:0] gap_i,
  input  logic [1:0] burstlength_i,
  input  logic       dram_crc_en_i,
  output logic       preamble_valid_o,
  output logic       preamble_done_o,
  output logic       rddata_valid_o,
  output logic [4:0] rd_beat_o,
  output logic       crc_check_o,
  output logic       rddata_done_o,
  output logic       postamble_done_o,
  output logic       interamble_o,
  output logic       interamble_valid_o,
  output logic [2:0] interamble_shift_o,
  output logic       interamble_done_o,
  output logic       overflow_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_DATA  = 3'd2,
    S_POST  = 3'd3,
    S_GAP   = 3'd4,
    S_INTER = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] MAX_PRE_C = CNT_W'(MAX_PRE);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [2:0]       pre_lat_q;
  logic [1:0]       post_lat_q;
  logic [3:0]       gap_lat_q;
  logic [1:0]       bl_lat_q;
  logic             crc_lat_q;

  logic [CNT_W-1:0] pre_len, post_len, data_len, sum_len, gap_ext, gap_len;
  logic             inter_raw, data_last;
  logic             latch_cfg, consume, restart, set_pend;

  // Phase lengths are always derived from the latched configuration.
  always_comb begin
    if (pre_lat_q == 3'd0) begin
      pre_len = ONE_C;
    end else if (CNT_W'(pre_lat_q) > MAX_PRE_C) begin
      pre_len = MAX_PRE_C;
    end else begin
      pre_len = CNT_W'(pre_lat_q);
    end
    post_len = CNT_W'(post_lat_q) + ONE_C;
    unique case (bl_lat_q)
      2'b01:   data_len = CNT_W'(4);
      2'b10:   data_len = CNT_W'(16);
      default: data_len = CNT_W'(8);
    endcase
    data_len  = data_len + CNT_W'(crc_lat_q);
    sum_len   = pre_len + post_len;
    gap_ext   = CNT_W'(gap_lat_q);
    inter_raw = gap_ext < sum_len;
    // Only meaningful when the gap covers both ambles; otherwise treat as zero.
    gap_len   = inter_raw ? '0 : gap_ext - sum_len;
  end

  assign data_last = (state_q == S_DATA) && (cnt_q == data_len - ONE_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + ONE_C;
    restart   = 1'b0;
    latch_cfg = 1'b0;
    consume   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rd_en_i) begin
          state_d   = S_PRE;
          latch_cfg = 1'b1;
        end
      end
      S_PRE: begin
        if (cnt_q == pre_len - ONE_C) begin
          state_d   = S_DATA;
          latch_cfg = 1'b1;
        end
      end
      S_DATA: begin
        if (data_last) begin
          if (pending_q && inter_raw) begin
            consume = 1'b1;
            if (gap_lat_q == 4'd0) begin
              restart   = 1'b1;
              latch_cfg = 1'b1;
            end else begin
              state_d = S_INTER;
            end
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (cnt_q == post_len - ONE_C) begin
          if (!pending_q) begin
            state_d = S_IDLE;
          end else if (gap_len == '0) begin
            state_d = S_PRE;
            consume = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == gap_len - ONE_C) begin
          state_d = S_PRE;
          consume = 1'b1;
        end
      end
      S_INTER: begin
        if (cnt_q == gap_ext - ONE_C) begin
          state_d   = S_DATA;
          latch_cfg = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d != state_q) || restart) begin
      cnt_d = '0;
    end
  end

  // A command landing in the cycle the slot is consumed refills it without overflow.
  assign set_pend   = rd_en_i && (state_q != S_IDLE);
  assign pending_d  = (pending_q && !consume) || set_pend;
  assign overflow_d = overflow_q || (set_pend && pending_q && !consume);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      pre_lat_q  <= '0;
      post_lat_q <= '0;
      gap_lat_q  <= '0;
      bl_lat_q   <= '0;
      crc_lat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      if (latch_cfg) begin
        pre_lat_q  <= precycle_i;
        post_lat_q <= postcycle_i;
        gap_lat_q  <= gap_i;
        bl_lat_q   <= burstlength_i;
        crc_lat_q  <= dram_crc_en_i;
      end
    end
  end

  always_comb begin
    busy_o             = (state_q != S_IDLE);
    preamble_valid_o   = (state_q == S_PRE);
    preamble_done_o    = (state_q == S_PRE) && (cnt_q == pre_len - ONE_C);
    rddata_valid_o     = (state_q == S_DATA);
    rd_beat_o          = (state_q == S_DATA) ? 5'(cnt_q) : 5'd0;
    crc_check_o        = data_last && crc_lat_q;
    rddata_done_o      = data_last;
    postamble_done_o   = (state_q == S_POST) && (cnt_q == post_len - ONE_C);
    interamble_o       = busy_o && inter_raw;
    interamble_valid_o = (state_q == S_INTER);
    interamble_shift_o = 3'd0;
    if (state_q == S_INTER) begin
      interamble_shift_o = (cnt_q > CNT_W'(7)) ? 3'd7 : cnt_q[2:0];
    end
    interamble_done_o  = (state_q == S_INTER) && (cnt_q == gap_ext - ONE_C);
    overflow_o         = overflow_q;
  end

endmodule

// File: tb/tb_read_counter.sv
// Directed bench for read_counter: each phase helper checks every output, cycle by cycle,
// against hand-derived phase lengths.
module tb_read_counter;
  logic       clk = 1'b0;
  logic       rst, rd_en, crc_en;
  logic [2:0] pre;
  logic [1:0] post, bl;
  logic [3:0] gap;

  logic       pv, pd, dv, crc_chk, dd, postd, ia, iv, idone, ovf, busy;
  logic [4:0] beat;
  logic [2:0] shift;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ovf_cyc = -1;
  logic exp_ia = 1'b0;

  always #5 clk = ~clk;

  read_counter dut (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en),
    .precycle_i(pre), .postcycle_i(post), .gap_i(gap),
    .burstlength_i(bl), .dram_crc_en_i(crc_en),
    .preamble_valid_o(pv), .preamble_done_o(pd),
    .rddata_valid_o(dv), .rd_beat_o(beat), .crc_check_o(crc_chk),
    .rddata_done_o(dd), .postamble_done_o(postd),
    .interamble_o(ia), .interamble_valid_o(iv),
    .interamble_shift_o(shift), .interamble_done_o(idone),
    .overflow_o(ovf), .busy_o(busy)
  );

  task automatic step(input logic pulse);
    rd_en = pulse;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    cyc++;
    if (rst) ovf_cyc = -1;
  endtask

  // Bit layout: pv pd dv beat[5] crc dd postd ia iv shift[3] idone ovf busy
  task automatic chk_step(input string tag, input logic [18:0] exp_in, input logic pulse);
    logic [18:0] obs;
    logic [18:0] exp_v;
    exp_v    = exp_in;
    exp_v[1] = (ovf_cyc >= 0) && (cyc >= ovf_cyc);
    obs = {pv, pd, dv, beat, crc_chk, dd, postd, ia, iv, shift, idone, ovf, busy};
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
    step(pulse);
  endtask

  task automatic ph_idle(input int n, input logic [31:0] mask);
    for (int k = 0; k < n; k++) chk_step("idle", 19'd0, mask[k]);
  endtask

  task automatic ph_pre(input int n, input logic [31:0] mask);
    logic [18:0] e;
    for (int k = 0; k < n; k++) begin
      e = '0; e[18] = 1'b1; e[17] = (k == n - 1); e[7] = exp_ia; e[0] = 1'b1;
      chk_step("preamble", e, mask[k]);
    end
  endtask

  task automatic ph_data(input int n, input int first, input int last, input logic crc,
                         input logic [31:0] mask);
    logic [18:0] e;
    for (int k = first; k < last; k++) begin
      e = '0; e[16] = 1'b1; e[15:11] = 5'(k); e[10] = crc && (k == n - 1);
      e[9] = (k == n - 1); e[7] = exp_ia; e[0] = 1'b1;
      chk_step("data", e, mask[k]);
    end
  endtask

  task automatic ph_post(input int n, input logic [31:0] mask);
    logic [18:0] e;
    for (int k = 0; k < n; k++) begin
      e = '0; e[8] = (k == n - 1); e[7] = exp_ia; e[0] = 1'b1;
      chk_step("postamble", e, mask[k]);
    end
  endtask

  task automatic ph_gap(input int n, input logic [31:0] mask);
    logic [18:0] e;
    for (int k = 0; k < n; k++) begin
      e = '0; e[7] = exp_ia; e[0] = 1'b1;
      chk_step("gap", e, mask[k]);
    end
  endtask

  task automatic ph_inter(input int n, input logic [31:0] mask);
    logic [18:0] e;
    for (int k = 0; k < n; k++) begin
      e = '0; e[7] = exp_ia; e[6] = 1'b1; e[5:3] = (k > 7) ? 3'd7 : 3'(k);
      e[2] = (k == n - 1); e[0] = 1'b1;
      chk_step("interamble", e, mask[k]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; pre = 3'd0; post = 2'd0; gap = 4'd0; bl = 2'b00; crc_en = 1'b0;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    ph_idle(2, 32'h0);

    // Single burst; burst length changed mid-DATA must not stretch it
    pre = 3'd2; post = 2'd1; gap = 4'd0; bl = 2'b00; crc_en = 1'b0; exp_ia = 1'b1;
    ph_idle(1, 32'h1);
    ph_pre(2, 32'h0);
    bl = 2'b10;
    ph_data(8, 0, 8, 1'b0, 32'h0);
    bl = 2'b00;
    ph_post(2, 32'h0);
    ph_idle(1, 32'h0);

    // CRC + BC8
    pre = 3'd1; post = 2'd0; bl = 2'b01; crc_en = 1'b1; exp_ia = 1'b1;
    ph_idle(1, 32'h1);
    ph_pre(1, 32'h0);
    ph_data(5, 0, 5, 1'b1, 32'h0);
    ph_post(1, 32'h0);
    ph_idle(1, 32'h0);

    // Interamble between back-to-back bursts
    pre = 3'd2; post = 2'd2; gap = 4'd3; bl = 2'b00; crc_en = 1'b0; exp_ia = 1'b1;
    ph_idle(1, 32'h1);
    ph_pre(2, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h2);
    ph_inter(3, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h0);
    ph_post(3, 32'h0);
    ph_idle(1, 32'h0);

    // Seamless: gap 0
    pre = 3'd2; post = 2'd1; gap = 4'd0; exp_ia = 1'b1;
    ph_idle(1, 32'h1);
    ph_pre(2, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h2);
    ph_data(8, 0, 8, 1'b0, 32'h0);
    ph_post(2, 32'h0);
    ph_idle(1, 32'h0);

    // Spaced: gap 6 -> 2 GAP cycles then a fresh preamble
    gap = 4'd6; exp_ia = 1'b0;
    ph_idle(1, 32'h1);
    ph_pre(2, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h2);
    ph_post(2, 32'h0);
    ph_gap(2, 32'h0);
    ph_pre(2, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h0);
    ph_post(2, 32'h0);
    ph_idle(1, 32'h0);

    // Consumed-then-set on the last beat: no overflow, a third burst follows
    pre = 3'd2; post = 2'd2; gap = 4'd3; exp_ia = 1'b1;
    ph_idle(1, 32'h1);
    ph_pre(2, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h82);
    ph_inter(3, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h0);
    ph_inter(3, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h0);
    ph_post(3, 32'h0);
    ph_idle(1, 32'h0);

    // Overflow: three pulses in one preamble, exactly two bursts run
    pre = 3'd4; post = 2'd0; gap = 4'd0; bl = 2'b01; exp_ia = 1'b1;
    ovf_cyc = cyc + 3;
    ph_idle(1, 32'h1);
    ph_pre(4, 32'h7);
    ph_data(4, 0, 4, 1'b0, 32'h0);
    ph_data(4, 0, 4, 1'b0, 32'h0);
    ph_post(1, 32'h0);
    ph_idle(2, 32'h0);
    do_reset();
    ph_idle(1, 32'h0);

    // Reset at DATA beat 3, then restart
    pre = 3'd2; post = 2'd1; gap = 4'd0; bl = 2'b00; exp_ia = 1'b1;
    ph_idle(1, 32'h1);
    ph_pre(2, 32'h0);
    ph_data(8, 0, 3, 1'b0, 32'h0);
    rst = 1'b1;
    ph_data(8, 3, 4, 1'b0, 32'h0);
    rst = 1'b0;
    ph_idle(1, 32'h1);
    ph_pre(2, 32'h0);
    ph_data(8, 0, 8, 1'b0, 32'h0);
    ph_post(2, 32'h0);
    ph_idle(1, 32'h0);

    // Preamble clamp: code 7 -> MAX_PRE cycles; code 0 -> 1 cycle
    pre = 3'd7; post = 2'd0; bl = 2'b01; exp_ia = 1'b1;
    ph_idle(1, 32'h1);
    ph_pre(4, 32'h0);
    ph_data(4, 0, 4, 1'b0, 32'h0);
    ph_post(1, 32'h0);
    pre = 3'd0;
    ph_idle(1, 32'h1);
    ph_pre(1, 32'h0);
    ph_data(4, 0, 4, 1'b0, 32'h0);
    ph_post(1, 32'h0);
    ph_idle(1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/read_counter.md
Name: read_counter

Overview:
- Read-path sequencing counter for the DDR5 PHY read block; the receive-side counterpart of the write counter.
- Accepts read-enable command pulses from the MC-side interface and sequences the expected DQS/DQ receive phases from DRAM: PREAMBLE, DATA (plus optional CRC cycle), then POSTAMBLE, GAP or INTERAMBLE.
- Drives capture-window, done and error flags consumed by the read capture datapath and the read controller.
- One clock cycle = one PHY clock; all lengths below are in clk_i cycles.

Parameters:
- MAX_PRE, 4, upper clamp for preamble length.
- CNT_W, 5, width of the internal phase counter; must hold 17, the largest data length.

Ports:
- clk_i  in  1  PHY clock.
- rst_i  in  1  reset: one clock, synchronous, active-high.
- rd_en_i  in  1  one-cycle read command pulse.
- precycle_i  in  3  preamble length code.
- postcycle_i  in  2  postamble length code.
- gap_i  in  4  cycles from last data cycle to next burst's first data cycle.
- burstlength_i  in  2  burst length code: 00=BL16, 01=BC8, 10=BL32, 11=BL16.
- dram_crc_en_i  in  1  DRAM appends read CRC.
- preamble_valid_o  out  1  high in every PREAMBLE cycle.
- preamble_done_o  out  1  pulse on last PREAMBLE cycle.
- rddata_valid_o  out  1  high in every DATA cycle, including the CRC cycle.
- rd_beat_o  out  5  index of the current DATA cycle, 0-based.
- crc_check_o  out  1  pulse on the CRC cycle.
- rddata_done_o  out  1  pulse on last DATA cycle.
- postamble_done_o  out  1  pulse on last POSTAMBLE cycle.
- interamble_o  out  1  combinational: gap_lat < pre_len+post_len.
- interamble_valid_o  out  1  high in INTERAMBLE.
- interamble_shift_o  out  3  cycle index within INTERAMBLE, saturates at 7.
- interamble_done_o  out  1  pulse on last INTERAMBLE cycle.
- overflow_o  out  1  sticky: command dropped.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state=IDLE, counter=0, pending=0, overflow_o=0. Reset mid-burst aborts immediately; next cycle is IDLE.
- Derived lengths:
  - pre_len = clamp(precycle_i, 1, MAX_PRE).
  - post_len = postcycle_i+1.
  - data_len = 8/4/16/8 for burstlength_i 00/01/10/11, +1 if dram_crc_en_i.
- Config latch: precycle_i, postcycle_i, gap_i, burstlength_i and dram_crc_en_i are latched (*_lat) on the IDLE->PREAMBLE transition and again on every DATA entry. Inputs may change at any other time without effect.
- FSM states: IDLE, PREAMBLE, DATA, POSTAMBLE, GAP, INTERAMBLE. The counter clears on every state entry.
- IDLE: rd_en_i=1 -> PREAMBLE next cycle. The command is consumed and does not set pending.
- PREAMBLE: lasts pre_len cycles. preamble_done_o pulses when counter==pre_len-1, then -> DATA.
- DATA: lasts data_len cycles and rd_beat_o=counter.
  - crc_check_o pulses on beat data_len-1 when dram_crc_en_lat=1.
  - rddata_done_o pulses on beat data_len-1.
  - Exit when pending=1 and interamble_o=1: gap_lat==0 -> DATA again (seamless, no gap cycle); else -> INTERAMBLE. pending clears.
  - Exit when pending=1 and interamble_o=0: -> POSTAMBLE. pending stays set.
  - Exit when pending=0: -> POSTAMBLE.
- POSTAMBLE: lasts post_len cycles; postamble_done_o pulses on the last cycle.
  - pending=1: -> GAP. GAP lasts gap_lat-pre_len-post_len cycles; if that is 0, go directly to PREAMBLE. pending clears on PREAMBLE entry.
  - pending=0: -> IDLE.
- INTERAMBLE: lasts gap_lat cycles, then -> DATA. interamble_shift_o=min(counter,7). interamble_done_o pulses on the last cycle.
- Pending slot (depth 1): rd_en_i in any state except IDLE sets pending.
  - rd_en_i while pending=1 -> command dropped, overflow_o set. overflow_o clears only on rst_i.
  - A rd_en_i arriving in the same cycle pending is consumed re-sets pending (consumed-then-set; no overflow).
- GAP: all flags low, busy_o=1.
- Comparisons are unsigned. gap_lat-pre_len-post_len is evaluated only when interamble_o=0, so it never underflows.

Test Plan:
- Single burst: rst, precycle=2, postcycle=1, BL16, crc=0, one rd_en_i pulse at cycle 0 -> preamble_valid_o cycles 1-2, preamble_done_o at 2, rddata_valid_o cycles 3-10 with rd_beat_o 0..7, rddata_done_o at 10, postamble_done_o at 12, busy_o low from 13.
- CRC + BC8: precycle=1, crc=1, BC8 -> 5 DATA cycles, crc_check_o and rddata_done_o both on beat 4.
- Interamble: pre=2, post=2, gap=3, second rd_en_i during DATA -> INTERAMBLE 3 cycles, interamble_shift_o 0,1,2, interamble_done_o on 3rd, second DATA follows with no preamble.
- Seamless and spaced: gap=0 -> second DATA immediately after first (rd_beat_o 7 then 0). gap=6, pre=2, post=1 -> POSTAMBLE 2 cycles, GAP 2 cycles, PREAMBLE 2 cycles.
- Overflow: three rd_en_i pulses during one PREAMBLE -> overflow_o=1 from the cycle after the 2nd extra pulse; exactly two bursts complete.
- Reset mid-DATA at beat 3 -> next cycle all outputs 0, busy_o=0; a new rd_en_i restarts from PREAMBLE.
